instr_fetch_unit: RTL and testbench

- Fetch stage that sits directly upstream of the RV32I core and supplies its instruction stream.
- Generates sequential fetch addresses from a PC register and issues reads to instruction memory over a req/gnt/rvalid interface with variable, in-order response latency.
- Buffers returned words in a small prefetch queue.
- Presents words to the core with a valid/ready handshake, each tagged with its PC.
- Accepts redirects from the branch/jump logic, which flush the queue and discard in-flight stale responses.

---
 rtl/instr_fetch_unit_if.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, core-side
// valid/ready instruction port and the instruction memory bus.
interface instr_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction_code;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    input  instr_ready,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    output instr_valid,
    output instruction_code,
    output instr_pc,
    output mem_req,
    output mem_addr
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    output instr_ready,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    input  instr_valid,
    input  instruction_code,
    input  instr_pc,
    input  mem_req,
    input  mem_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC fetch, prefetch queue,
// redirect flush with in-order stale response dropping.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(DEPTH * 2) + 1;

  typedef struct packed {
    logic        filled;
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ucnt_q, ucnt_d;
  logic [SW-1:0] stale_q, stale_d;
  logic          gnt_ev, fill_ev, pop_ev, drop_ev;

  assign bus.mem_req = rst
                    && !bus.redirect_valid
                    && (cnt_q < CW'(DEPTH));
  assign bus.mem_addr = rst ? fetch_pc_q : '0;

  assign bus.instr_valid = (cnt_q != '0)
                        && ent_q[head_q].filled;
  assign bus.instruction_code = ent_q[head_q].data;
  assign bus.instr_pc = ent_q[head_q].pc;

  always_comb begin
    gnt_ev  = bus.mem_req && bus.mem_gnt;
    drop_ev = bus.mem_rvalid && (stale_q != '0);
    fill_ev = bus.mem_rvalid
           && (stale_q == '0)
           && (ucnt_q != '0)
           && !bus.redirect_valid;
    pop_ev  = bus.instr_valid
           && bus.instr_ready
           && !bus.redirect_valid;
  end

  always_comb begin
    ent_d      = ent_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    ucnt_d     = ucnt_q;
    stale_d    = stale_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      ucnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].filled = 1'b0;
      end
      // unfilled reads become stale; a response now is one of them
      stale_d = stale_q + SW'(ucnt_q);
      if (bus.mem_rvalid && stale_d != '0) begin
        stale_d = stale_d - SW'(1);
      end
    end else begin
      if (gnt_ev) begin
        ent_d[tail_q].filled = 1'b0;
        ent_d[tail_q].pc = fetch_pc_q;
        tail_d = tail_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (fill_ev) begin
        ent_d[fill_q].data = bus.mem_rdata;
        ent_d[fill_q].filled = 1'b1;
        fill_d = fill_q + 1'b1;
      end
      if (pop_ev) begin
        head_d = head_q + 1'b1;
      end
      if (drop_ev) begin
        stale_d = stale_q - SW'(1);
      end
      cnt_d  = cnt_q + CW'(gnt_ev) - CW'(pop_ev);
      ucnt_d = ucnt_q + CW'(gnt_ev) - CW'(fill_ev);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q      <= '0;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      ucnt_q     <= '0;
      stale_q    <= '0;
    end else begin
      ent_q      <= ent_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      ucnt_q     <= ucnt_d;
      stale_q    <= stale_d;
    end
  end

  a_rvalid_expected: assert property (
    @(posedge clk) disable iff (!rst)
    bus.mem_rvalid |-> (stale_q != '0 || ucnt_q != '0)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table-driven fetch
// trace plus hand-written backpressure/redirect/reset cases.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifa();
  instr_fetch_unit_if ifw();

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  instr_fetch_unit #(
    .RESET_PC(32'hFFFF_FFF8),
    .DEPTH(4)
  ) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(ifw)
  );

  assign ifw.redirect_valid = 1'b0;
  assign ifw.redirect_pc    = 32'h0;
  assign ifw.instr_ready    = 1'b0;
  assign ifw.mem_gnt        = 1'b1;
  assign ifw.mem_rvalid     = 1'b0;
  assign ifw.mem_rdata      = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    bit          ready;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
    bit          wreq;
    logic [31:0] waddr;
  } vec_t;

  pend_t       pend[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  vec_t        tbl[8];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_en = 1'b1;
  logic [31:0] exp_pc = 32'h0;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // first half of a cycle: drive memory, settle, record
  task automatic cyc_a();
    @(negedge clk);
    ifa.mem_gnt = gnt_en;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      ifa.mem_rvalid = 1'b1;
      ifa.mem_rdata  = mem_word(pend[0].addr);
    end else begin
      ifa.mem_rvalid = 1'b0;
      ifa.mem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (ifa.mem_req && ifa.mem_gnt) begin
      pend.push_back('{addr: ifa.mem_addr, due: cyc + lat});
      gnt_log.push_back(ifa.mem_addr);
    end
    if (ifa.mem_rvalid) pend.delete(0);
    if (ifa.instr_valid && ifa.instr_ready
        && !ifa.redirect_valid) begin
      chk("pop_pc", ifa.instr_pc, exp_pc);
      chk("pop_code", ifa.instruction_code,
          mem_word(exp_pc));
      pop_log.push_back(ifa.instr_pc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic cyc_b();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    cyc_a();
    cyc_b();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pend.delete();
    ifa.mem_rvalid     = 1'b0;
    ifa.mem_gnt        = 1'b0;
    ifa.redirect_valid = 1'b0;
    ifa.instr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    exp_pc = 32'h0;
    gnt_log.delete();
    pop_log.delete();
  endtask

  initial begin
    // ready, req, addr, vld, pc, wrap req, wrap addr
    tbl[0] = '{1, 1, 32'h00, 0, 32'h00, 1, 32'hFFFF_FFF8};
    tbl[1] = '{1, 1, 32'h04, 0, 32'h00, 1, 32'hFFFF_FFFC};
    tbl[2] = '{1, 1, 32'h08, 1, 32'h00, 1, 32'h0000_0000};
    tbl[3] = '{1, 1, 32'h0C, 1, 32'h04, 1, 32'h0000_0004};
    tbl[4] = '{0, 1, 32'h10, 1, 32'h08, 0, 32'h0000_0008};
    tbl[5] = '{1, 1, 32'h14, 1, 32'h08, 0, 32'h0000_0008};
    tbl[6] = '{1, 1, 32'h18, 1, 32'h0C, 0, 32'h0000_0008};
    tbl[7] = '{1, 1, 32'h1C, 1, 32'h10, 0, 32'h0000_0008};

    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = 32'h0;
    ifa.instr_ready    = 1'b0;
    ifa.mem_gnt        = 1'b0;
    ifa.mem_rvalid     = 1'b0;
    ifa.mem_rdata      = 32'h0;
    #1 rst = 1'b0;
    #2;
    chk("rst_req", ifa.mem_req, 0);
    chk("rst_valid", ifa.instr_valid, 0);
    chk("rst_addr", ifa.mem_addr, 0);
    chk("rst_pc", ifa.instr_pc, 0);
    chk("rst_code", ifa.instruction_code, 0);

    // sequential fetch trace, one stall cycle on the core side
    do_reset();
    lat = 1;
    gnt_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifa.instr_ready = tbl[i].ready;
      cyc_a();
      chk($sformatf("seq%0d_req", i), ifa.mem_req, tbl[i].req);
      chk($sformatf("seq%0d_addr", i), ifa.mem_addr, tbl[i].addr);
      chk($sformatf("seq%0d_vld", i), ifa.instr_valid, tbl[i].vld);
      chk($sformatf("seq%0d_pc", i), ifa.instr_pc, tbl[i].pc);
      chk($sformatf("wrap%0d_req", i), ifw.mem_req, tbl[i].wreq);
      chk($sformatf("wrap%0d_addr", i), ifw.mem_addr, tbl[i].waddr);
      cyc_b();
    end

    // backpressure: queue fills with exactly DEPTH reads
    do_reset();
    lat = 1;
    gnt_en = 1'b1;
    ifa.instr_ready = 1'b0;
    repeat (10) tick();
    cyc_a();
    chk("bp_grants", gnt_log.size(), 4);
    chk("bp_req_low", ifa.mem_req, 0);
    chk("bp_valid", ifa.instr_valid, 1);
    chk("bp_head_pc", ifa.instr_pc, 32'h0);
    cyc_b();
    ifa.instr_ready = 1'b1;
    gnt_log.delete();
    repeat (8) tick();
    chk("bp_resume_addr",
        gnt_log.size() > 0 ? gnt_log[0] : 32'hFFFF_FFFF,
        32'h10);
    chk("bp_pop3",
        pop_log.size() > 3 ? pop_log[3] : 32'hFFFF_FFFF,
        32'h0C);

    // redirect with two reads in flight at latency 3
    do_reset();
    lat = 3;
    gnt_en = 1'b1;
    ifa.instr_ready = 1'b1;
    tick();
    tick();
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h0000_0102;
    exp_pc = 32'h100;
    cyc_a();
    chk("rd_req_low", ifa.mem_req, 0);
    cyc_b();
    ifa.redirect_valid = 1'b0;
    gnt_log.delete();
    pop_log.delete();
    repeat (12) tick();
    chk("rd_first_addr",
        gnt_log.size() > 0 ? gnt_log[0] : 32'hFFFF_FFFF,
        32'h100);
    chk("rd_first_pop",
        pop_log.size() > 0 ? pop_log[0] : 32'hFFFF_FFFF,
        32'h100);

    // redirect in the same cycle as a pop and a fill
    do_reset();
    lat = 1;
    gnt_en = 1'b1;
    ifa.instr_ready = 1'b1;
    repeat (4) tick();
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc = 32'h0000_0200;
    exp_pc = 32'h200;
    cyc_a();
    chk("co_valid_pre", ifa.instr_valid, 1);
    chk("co_rvalid_pre", ifa.mem_rvalid, 1);
    cyc_b();
    ifa.redirect_valid = 1'b0;
    cyc_a();
    chk("co_valid_after", ifa.instr_valid, 0);
    chk("co_req_after", ifa.mem_req, 1);
    chk("co_addr_after", ifa.mem_addr, 32'h200);
    cyc_b();
    repeat (8) tick();
    chk("co_pop_prior", pop_log.size() > 1 ? pop_log[1] : 32'hFFFF_FFFF, 32'h4);
    chk("co_pop_next", pop_log.size() > 2 ? pop_log[2] : 32'hFFFF_FFFF, 32'h200);

    // async reset in the middle of a withheld grant
    do_reset();
    lat = 1;
    gnt_en = 1'b1;
    ifa.instr_ready = 1'b0;
    tick();
    tick();
    gnt_en = 1'b0;
    repeat (3) tick();
    cyc_a();
    chk("ar_req_hold", ifa.mem_req, 1);
    chk("ar_addr_hold", ifa.mem_addr, 32'h8);
    chk("ar_valid_pre", ifa.instr_valid, 1);
    cyc_b();
    #2 rst = 1'b0;
    #1;
    chk("ar_req_drop", ifa.mem_req, 0);
    chk("ar_valid_drop", ifa.instr_valid, 0);
    chk("ar_addr_clr", ifa.mem_addr, 0);
    pend.delete();
    ifa.mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    exp_pc = 32'h0;
    gnt_en = 1'b1;
    gnt_log.delete();
    tick();
    chk("ar_first_addr",
        gnt_log.size() > 0 ? gnt_log[0] : 32'hFFFF_FFFF,
        32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
